grid_update_rx: RTL and testbench
=================================

# grid_update_rx

Receives maze-square updates from the robot's Arduino over a 4-bit, 4-phase REQ/ACK GPIO link and turns them into single-cycle writes into the grid colour memory that the VGA pixel logic reads. It sits between the GPIO_1 pins and the grid array in the top level, in the CLOCK_25 domain. Each packet is three nibbles (X, Y, state code). Malformed or stalled packets are dropped and counted.

## Interface
- GRID_W, 4: grid columns; valid X is 0..GRID_W-1
- GRID_H, 5: grid rows; valid Y is 0..GRID_H-1
- TIMEOUT, 25000: max CLOCK cycles between nibbles of one packet (1 ms at 25 MHz)
- CLOCK  in  1  25 MHz system clock (CLOCK_25)
- RESET_N  in  1  asynchronous, active-low reset
- REQ  in  1  Arduino request, asynchronous to CLOCK
- DATA_IN  in  4  nibble; stable from REQ rise until ACK seen high
- ACK  out  1  acknowledge to Arduino
- WR_EN  out  1  one-cycle grid write strobe
- WR_X  out  3  column of write
- WR_Y  out  3  row of write
- WR_COLOR  out  8  RGB332 colour of write
- ERR  out  1  one-cycle pulse on dropped packet
- ERR_COUNT  out  8  saturating count of dropped packets

## Operation
- REQ passes through a 2-FF synchroniser → req_s. DATA_IN is captured unsynchronised, on the edge where the nibble is accepted (bundled data).
- Handshake, 4-phase:
  - A nibble is accepted when req_s=1 and ACK=0. On that edge: latch DATA_IN, ACK←1, nib_valid pulses for 1 cycle.
  - ACK stays 1 while req_s=1. On the first edge with req_s=0, ACK←0.
  - No further nibble is accepted until ACK=0 again.
- Packet FSM states: S_X, S_Y, S_CODE, S_WRITE.
  - S_X, on nib_valid: store x, go to S_Y.
  - S_Y, on nib_valid: store y, go to S_CODE.
  - S_CODE, on nib_valid: store code, go to S_WRITE.
  - S_WRITE: validate, then unconditionally go to S_X.
- Validation in S_WRITE: x<GRID_W, y<GRID_H and code≤3.
  - Valid: WR_EN=1 for that cycle.
  - Invalid: ERR=1 for that cycle, ERR_COUNT+1.
- Code→colour mapping:
  - 0 unexplored → 000_000_00
  - 1 visited → 000_111_00
  - 2 wall → 000_000_11
  - 3 robot → 111_000_00
- Timeout:
  - A 15-bit counter clears on every nib_valid and counts while in S_Y or S_CODE.
  - When it reaches TIMEOUT: go to S_X, ERR pulse, ERR_COUNT+1. Partial data is discarded.
- ERR_COUNT saturates at 255.
- nib_valid in S_WRITE cannot occur (the handshake needs at least 2 cycles). Nonetheless, nib_valid arriving in S_WRITE is ignored; the handshake still completes.

## Timing
- Reset values: ACK=0, WR_EN=0, WR_X=0, WR_Y=0, WR_COLOR=0, ERR=0, ERR_COUNT=0, FSM=S_X, synchroniser=0, timeout counter=0.
- Reset asserted mid-packet: partial packet is lost; no WR_EN or ERR is generated for it.
- Acceptance latency: REQ rise sampled at edge n → req_s=1 after edge n+1 → ACK=1 after edge n+2.
- Release latency: REQ fall → ACK=0 after 3 edges.
- Write latency: third nib_valid at edge k → WR_EN, WR_X, WR_Y, WR_COLOR valid for exactly the cycle after edge k+1. WR_X, WR_Y, WR_COLOR hold their last values afterwards.
- Minimum packet time is 3 × ~6 cycles. The block accepts back-to-back packets with no dead time beyond S_WRITE.
- Timeout fires exactly TIMEOUT cycles after the last nib_valid when no further nibble arrives. A nib_valid on the same edge as the terminal count wins: the nibble is accepted and the counter clears.

## Structure
- Shared package (grid_pkg):
  - colour constants BLACK, RED, GREEN, BLUE (RGB332)
  - state-code constants CODE_UNEXPLORED..CODE_ROBOT
  - default GRID_W and GRID_H
- Sub-module handshake_rx: synchroniser, ACK generation, nibble latch, nib_valid.
- Parent grid_update_rx: packet FSM, timeout counter, validation, colour LUT, error counter.

## Test plan
- Packet (2,3,1) with well-behaved handshake → exactly one WR_EN with WR_X=2, WR_Y=3, WR_COLOR=000_111_00. ACK mirrors REQ with 2–3 cycle lag each phase.
- Packet (4,0,2), X out of range → no WR_EN, ERR pulse, ERR_COUNT=1. Then packet (0,0,3) → WR_COLOR=111_000_00.
- Packet (1,1,7), illegal code → ERR, no write.
- Send X and Y, then stall TIMEOUT cycles → ERR at exactly TIMEOUT cycles, FSM back in S_X. Then full packet (3,4,0) → write with colour 000_000_00.
- RESET_N pulsed low after the second nibble → all outputs return to reset values immediately. Next three nibbles form a fresh packet and write correctly.
- 300 consecutive invalid packets → ERR_COUNT stops at 255. Randomised REQ skew relative to CLOCK never produces double acceptance of one nibble.

Source files
------------

// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
// grid_pkg : shared constants for the maze grid update receiver
// Rev 1.0  : initial release
// ============================================================================
package grid_pkg;

    localparam int NIB_W      = 4;
    localparam int GRID_W_DEF = 4;
    localparam int GRID_H_DEF = 5;

    // RGB332 colours
    localparam logic [7:0] BLACK = 8'b000_000_00;
    localparam logic [7:0] RED   = 8'b111_000_00;
    localparam logic [7:0] GREEN = 8'b000_111_00;
    localparam logic [7:0] BLUE  = 8'b000_000_11;

    localparam logic [NIB_W-1:0] CODE_UNEXPLORED = 4'd0;
    localparam logic [NIB_W-1:0] CODE_VISITED    = 4'd1;
    localparam logic [NIB_W-1:0] CODE_WALL       = 4'd2;
    localparam logic [NIB_W-1:0] CODE_ROBOT      = 4'd3;

    typedef enum logic [1:0] {
        S_X     = 2'd0,
        S_Y     = 2'd1,
        S_CODE  = 2'd2,
        S_WRITE = 2'd3
    } pkt_state_t;

    function automatic logic [7:0] code_to_color(input logic [NIB_W-1:0] code);
        case (code)
            CODE_UNEXPLORED: code_to_color = BLACK;
            CODE_VISITED:    code_to_color = GREEN;
            CODE_WALL:       code_to_color = BLUE;
            CODE_ROBOT:      code_to_color = RED;
            default:         code_to_color = BLACK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_update_rx_if.sv
`default_nettype none
// ============================================================================
// grid_update_rx_if : Arduino nibble link plus grid write port
// Rev 1.0 : initial release
// ============================================================================
interface grid_update_rx_if
    import grid_pkg::*;
;
    logic             req;
    logic [NIB_W-1:0] data_in;
    logic             ack;
    logic             wr_en;
    logic [2:0]       wr_x;
    logic [2:0]       wr_y;
    logic [7:0]       wr_color;
    logic             err;
    logic [7:0]       err_count;

    modport master (
        output req, data_in,
        input  ack, wr_en, wr_x, wr_y, wr_color, err, err_count
    );

    modport slave (
        input  req, data_in,
        output ack, wr_en, wr_x, wr_y, wr_color, err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/grid_update_rx_handshake.sv
`default_nettype none
// ============================================================================
// handshake_rx : 4-phase REQ/ACK receiver with 2-FF REQ synchroniser
// Rev 1.0 : initial release
// ============================================================================
module handshake_rx
    import grid_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             req,
    input  wire logic [NIB_W-1:0] data_in,
    output logic                  ack,
    output logic                  nib_valid,
    output logic [NIB_W-1:0]      nibble
);

    logic r_req_meta;
    logic r_req_sync;
    logic r_ack;
    logic w_accept;

    // ACK low is the only window in which a new nibble may be taken, so a
    // long REQ high can never be accepted twice.
    assign w_accept = r_req_sync & ~r_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_meta <= 1'b0;
            r_req_sync <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_req_meta <= req;
            r_req_sync <= r_req_meta;
            if (w_accept) begin
                r_ack <= 1'b1;
            end else if (!r_req_sync) begin
                r_ack <= 1'b0;
            end
        end
    end

    // Bundled data: DATA_IN is stable while REQ is high and ACK low, so the
    // parent's field registers latch it directly on the accept edge.
    assign ack       = r_ack;
    assign nib_valid = w_accept;
    assign nibble    = data_in;

endmodule
`default_nettype wire

// File: rtl/grid_update_rx.sv
`default_nettype none
// ============================================================================
// grid_update_rx : assembles (X, Y, code) nibble packets into grid writes
// Rev 1.0 : initial release
// ============================================================================
module grid_update_rx
    import grid_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int TIMEOUT = 25000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    grid_update_rx_if.slave  bus
);

    localparam logic [NIB_W-1:0] c_grid_w   = NIB_W'(GRID_W);
    localparam logic [NIB_W-1:0] c_grid_h   = NIB_W'(GRID_H);
    localparam logic [14:0]      c_tmo_last = 15'(TIMEOUT - 1);

    logic             w_ack;
    logic             w_nib_valid;
    logic [NIB_W-1:0] w_nibble;

    handshake_rx u_handshake (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req),
        .data_in   (bus.data_in),
        .ack       (w_ack),
        .nib_valid (w_nib_valid),
        .nibble    (w_nibble)
    );

    pkt_state_t       r_state, w_state_d;
    logic [NIB_W-1:0] r_x, r_y, r_code;
    logic [NIB_W-1:0] w_x_d, w_y_d, w_code_d;
    logic [14:0]      r_cnt, w_cnt_d;
    logic             w_wr_en_d, w_err_d, w_pkt_ok;
    logic             r_wr_en, r_err;
    logic [2:0]       r_wr_x, r_wr_y;
    logic [7:0]       r_wr_color, r_err_count;

    assign w_pkt_ok = (r_x < c_grid_w) && (r_y < c_grid_h) && (r_code[3:2] == 2'b00);

    always_comb begin
        w_state_d = r_state;
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_code_d  = r_code;
        w_cnt_d   = r_cnt;
        w_wr_en_d = 1'b0;
        w_err_d   = 1'b0;
        case (r_state)
            S_X: begin
                if (w_nib_valid) begin
                    w_x_d     = w_nibble;
                    w_cnt_d   = '0;
                    w_state_d = S_Y;
                end
            end
            S_Y: begin
                if (w_nib_valid) begin
                    w_y_d     = w_nibble;
                    w_cnt_d   = '0;
                    w_state_d = S_CODE;
                end else if (r_cnt == c_tmo_last) begin
                    w_cnt_d   = '0;
                    w_err_d   = 1'b1;
                    w_state_d = S_X;
                end else begin
                    w_cnt_d = r_cnt + 15'd1;
                end
            end
            S_CODE: begin
                if (w_nib_valid) begin
                    w_code_d  = w_nibble;
                    w_cnt_d   = '0;
                    w_state_d = S_WRITE;
                end else if (r_cnt == c_tmo_last) begin
                    w_cnt_d   = '0;
                    w_err_d   = 1'b1;
                    w_state_d = S_X;
                end else begin
                    w_cnt_d = r_cnt + 15'd1;
                end
            end
            S_WRITE: begin
                // A nibble here is physically impossible; it is simply dropped.
                w_state_d = S_X;
                if (w_pkt_ok) begin
                    w_wr_en_d = 1'b1;
                end else begin
                    w_err_d = 1'b1;
                end
            end
            default: w_state_d = S_X;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_X;
            r_x         <= '0;
            r_y         <= '0;
            r_code      <= '0;
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_err       <= 1'b0;
            r_wr_x      <= '0;
            r_wr_y      <= '0;
            r_wr_color  <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_x     <= w_x_d;
            r_y     <= w_y_d;
            r_code  <= w_code_d;
            r_cnt   <= w_cnt_d;
            r_wr_en <= w_wr_en_d;
            r_err   <= w_err_d;
            if (w_wr_en_d) begin
                r_wr_x     <= r_x[2:0];
                r_wr_y     <= r_y[2:0];
                r_wr_color <= code_to_color(r_code);
            end
            if (w_err_d && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.ack       = w_ack;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_x      = r_wr_x;
    assign bus.wr_y      = r_wr_y;
    assign bus.wr_color  = r_wr_color;
    assign bus.err       = r_err;
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_grid_update_rx.sv
`default_nettype none
// ============================================================================
// tb_grid_update_rx : directed packets, scoreboard-checked write/error events
// Rev 1.0 : initial release
// ============================================================================
module tb_grid_update_rx;

    localparam int TMO = 100;

    typedef struct {
        bit         is_err;
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] color;
        logic [7:0] ecnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #20 clk = ~clk;

    grid_update_rx_if bus ();

    grid_update_rx #(
        .GRID_W  (4),
        .GRID_H  (5),
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned last_err_cyc = 0;
    int unsigned last_ack_cyc = 0;
    int          err_seen    = 0;
    int          exp_ecnt    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_color(input int code);
        case (code)
            0:       exp_color = 8'b000_000_00;
            1:       exp_color = 8'b000_111_00;
            2:       exp_color = 8'b000_000_11;
            default: exp_color = 8'b111_000_00;
        endcase
    endfunction

    // Monitor: every write or error strobe must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (bus.wr_en === 1'b1 || bus.err === 1'b1)) begin
            if (bus.err === 1'b1) begin
                err_seen++;
                last_err_cyc = cyc;
            end
            if (sb.size() == 0) begin
                check("unexpected_event", {30'd0, bus.wr_en, bus.err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("event_is_err", bus.err, mon_e.is_err);
                check("event_is_wr", bus.wr_en, !mon_e.is_err);
                if (mon_e.is_err) begin
                    check("err_count", bus.err_count, mon_e.ecnt);
                end else begin
                    check("wr_x", bus.wr_x, mon_e.x);
                    check("wr_y", bus.wr_y, mon_e.y);
                    check("wr_color", bus.wr_color, mon_e.color);
                end
            end
        end
    end

    task automatic send_nibble(input logic [3:0] v);
        int edges;
        @(posedge clk);
        #($urandom_range(2, 37));
        bus.data_in = v;
        bus.req     = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1; edges++;
        end while (bus.ack !== 1'b1 && edges < 20);
        last_ack_cyc = cyc;
        check("ack_rise_lag", edges, 3);
        #($urandom_range(2, 37));
        bus.req     = 1'b0;
        bus.data_in = 4'($urandom);
        edges = 0;
        do begin
            @(posedge clk); #1; edges++;
        end while (bus.ack !== 1'b0 && edges < 20);
        check("ack_fall_lag", edges, 3);
    endtask

    task automatic push_err();
        exp_t e;
        if (exp_ecnt < 255) exp_ecnt++;
        e.is_err = 1'b1;
        e.x = '0; e.y = '0; e.color = '0;
        e.ecnt = 8'(exp_ecnt);
        sb.push_back(e);
    endtask

    task automatic send_packet(input int x, input int y, input int code);
        exp_t e;
        if (x < 4 && y < 5 && code <= 3) begin
            e.is_err = 1'b0;
            e.x      = 3'(x);
            e.y      = 3'(y);
            e.color  = exp_color(code);
            e.ecnt   = '0;
            sb.push_back(e);
        end else begin
            push_err();
        end
        send_nibble(4'(x));
        send_nibble(4'(y));
        send_nibble(4'(code));
    endtask

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int start;
        int unsigned y_ack;
        rst_n       = 1'b0;
        bus.req     = 1'b0;
        bus.data_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", bus.ack, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_x", bus.wr_x, 0);
        check("rst_wr_y", bus.wr_y, 0);
        check("rst_wr_color", bus.wr_color, 0);
        check("rst_err", bus.err, 0);
        check("rst_err_count", bus.err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        send_packet(2, 3, 1);
        send_packet(4, 0, 2);
        send_packet(0, 0, 3);
        send_packet(1, 1, 7);
        send_packet(3, 4, 3);
        send_packet(0, 5, 0);

        // Stall after X and Y: error exactly TMO cycles after the Y accept.
        push_err();
        send_nibble(4'd1);
        send_nibble(4'd1);
        y_ack = last_ack_cyc;
        start = err_seen;
        for (int i = 0; i < TMO + 40 && err_seen == start; i++) @(posedge clk);
        check("timeout_fired", err_seen - start, 1);
        check("timeout_latency", last_err_cyc - y_ack, TMO);
        send_packet(3, 4, 0);

        // Reset mid-packet: the partial packet must vanish.
        send_nibble(4'd2);
        send_nibble(4'd2);
        #5 rst_n = 1'b0;
        #2;
        check("midrst_ack", bus.ack, 0);
        check("midrst_wr_en", bus.wr_en, 0);
        check("midrst_wr_x", bus.wr_x, 0);
        check("midrst_wr_y", bus.wr_y, 0);
        check("midrst_wr_color", bus.wr_color, 0);
        check("midrst_err", bus.err, 0);
        check("midrst_err_count", bus.err_count, 0);
        exp_ecnt = 0;
        repeat (2) @(posedge clk);
        #7 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        send_packet(1, 2, 2);

        for (int i = 0; i < 300; i++) begin
            send_packet(4 + (i % 12), i % 5, i % 4);
        end
        send_packet(0, 1, 1);

        repeat (20) @(posedge clk);
        #1;
        check("err_count_saturated", bus.err_count, 255);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
